// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU
// between NREQ valid/ready requesters, with one registered response slot.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   req_valid    : NREQ request-present bits, bit i = requester i
//   req_ready    : NREQ accept strobes (one-hot or all zero)
//   req_op1/op2  : packed operands, requester i at [i*XLEN +: XLEN]
//   req_alu_op   : packed 4-bit ALU opcodes, requester i at [i*4 +: 4]
//   alu_op1/op2  : operands driven to the shared ALU
//   alu_op_o     : opcode driven to the shared ALU
//   alu_result   : ALU result (combinational, same cycle)
//   alu_zero     : ALU zero flag (combinational, same cycle)
//   rsp_valid    : response slot holds a result
//   rsp_ready    : consumer takes the response this cycle
//   rsp_result   : registered ALU result
//   rsp_zero     : registered zero flag
//   rsp_id       : index of the requester owning the response

module alu_share_arbiter #(
  parameter  int NREQ = 2,
  parameter  int XLEN = 32,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  input  logic [NREQ*4-1:0]    req_alu_op,
  output logic [XLEN-1:0]      alu_op1,
  output logic [XLEN-1:0]      alu_op2,
  output logic [3:0]           alu_op_o,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic [IDW-1:0]       rsp_id
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_nxt;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic [IDW:0]   sum;
  logic           gnt_found;
  logic           slot_free;
  logic           gnt;

  // Slot can take a new result if empty or being drained now.
  assign slot_free = !rsp_valid || rsp_ready;

  // Rotating priority search starting at rr_ptr.
  // sum is one bit wider so rr_ptr+k never overflows
  // before the modulo fold.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      cand = sum[IDW-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // No grant while in reset so req_ready stays low.
  assign gnt = slot_free && gnt_found && !rst;

  // Ready strobes and ALU operand mux; idle inputs
  // are forced to zero/AND so the ALU sees no stale data.
  always_comb begin
    req_ready = '0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_op_o  = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt && (gnt_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        alu_op1      = req_op1[i*XLEN +: XLEN];
        alu_op2      = req_op2[i*XLEN +: XLEN];
        alu_op_o     = req_alu_op[i*4 +: 4];
      end
    end
  end

  // Next pointer: one past the winner, wrapping at NREQ-1.
  // With NREQ=1 the winner is always NREQ-1, so it stays 0.
  always_comb begin
    if (gnt_idx == IDW'(NREQ-1)) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = gnt_idx + IDW'(1);
    end
  end

  // Response slot and pointer. On drain without refill only
  // rsp_valid drops; the data fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
    end else if (gnt) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= gnt_idx;
      rr_ptr     <= rr_nxt;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter
// with a behavioural ALU, NREQ=2 and NREQ=4 instances.

module tb_alu_share_arbiter;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [1:0]  id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_op1, req_op2;
  logic [7:0]  req_alu_op;
  logic [31:0] alu_op1, alu_op2, alu_result, rsp_result;
  logic [3:0]  alu_op_o;
  logic        alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]  rsp_id;

  logic [3:0]   req_valid_4, req_ready_4;
  logic [127:0] req_op1_4, req_op2_4;
  logic [15:0]  req_alu_op_4;
  logic [31:0]  alu_op1_4, alu_op2_4, alu_result_4, rsp_result_4;
  logic [3:0]   alu_op_o_4;
  logic         alu_zero_4, rsp_valid_4, rsp_ready_4, rsp_zero_4;
  logic [1:0]   rsp_id_4;

  rsp_t sb[$];
  rsp_t sb4[$];
  rsp_t e, got;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [32:0] alu_f(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = {31'd0, $signed(a) < $signed(b)};
      4'b1100: r = a << b[4:0];
      4'b1101: r = a >> b[4:0];
      4'b1110: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result} = alu_f(alu_op1, alu_op2, alu_op_o);
  assign {alu_zero_4, alu_result_4} =
    alu_f(alu_op1_4, alu_op2_4, alu_op_o_4);

  alu_share_arbiter #(.NREQ(2), .XLEN(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_alu_op(req_alu_op),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_o(alu_op_o),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
  );

  alu_share_arbiter #(.NREQ(4), .XLEN(32)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_4), .req_ready(req_ready_4),
    .req_op1(req_op1_4), .req_op2(req_op2_4),
    .req_alu_op(req_alu_op_4),
    .alu_op1(alu_op1_4), .alu_op2(alu_op2_4), .alu_op_o(alu_op_o_4),
    .alu_result(alu_result_4), .alu_zero(alu_zero_4),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
    .rsp_result(rsp_result_4), .rsp_zero(rsp_zero_4),
    .rsp_id(rsp_id_4)
  );

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]          = v;
    req_alu_op[i*4 +: 4]  = op;
    req_op1[i*32 +: 32]   = a;
    req_op2[i*32 +: 32]   = b;
  endtask

  task automatic set_req4(input int i, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    req_valid_4[i]          = v;
    req_alu_op_4[i*4 +: 4]  = op;
    req_op1_4[i*32 +: 32]   = a;
    req_op2_4[i*32 +: 32]   = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    req_valid_4 = '0;
    rsp_ready = 1'b1;
    rsp_ready_4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    sb4.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    rsp_ready_4 = 1'b0;
    req_op1 = '0; req_op2 = '0; req_alu_op = '0;
    req_op1_4 = '0; req_op2_4 = '0; req_alu_op_4 = '0;
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd1);
    set_req(1, 1'b1, 4'b0010, 32'd1, 32'd1);
    req_valid_4 = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_ready got %b exp 00", req_ready);
    end
    n_cmp++;
    if (req_ready_4 !== 4'h0) begin
      n_err++; $display("FAIL reset_ready4 got %b exp 0000", req_ready_4);
    end
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_id} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_rsp got v=%b r=%h z=%b id=%h exp all 0",
               rsp_valid, rsp_result, rsp_zero, rsp_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    req_valid_4 = '0;
    rsp_ready = 1'b1;
    rsp_ready_4 = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready got %b exp 01", req_ready);
    end
    n_cmp++;
    if ({alu_op1, alu_op2, alu_op_o} !== {32'd5, 32'd7, 4'b0010}) begin
      n_err++;
      $display("FAIL single_alu_in got %h %h %h exp 5 7 2",
               alu_op1, alu_op2, alu_op_o);
    end
    sb.push_back('{32'd12, 1'b0, 2'd0});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL single_valid got %b exp 1", rsp_valid);
    end
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (got !== e) begin
      n_err++; $display("FAIL single_rsp got %h exp %h", got, e);
    end
    n_cmp++;
    if ({req_ready, alu_op1, alu_op2, alu_op_o} !== 70'd0) begin
      n_err++;
      $display("FAIL idle_alu_in got rdy=%b %h %h %h exp all 0",
               req_ready, alu_op1, alu_op2, alu_op_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_result} !== {1'b0, 32'd12}) begin
      n_err++;
      $display("FAIL drain_hold got v=%b r=%h exp v=0 r=0000000c",
               rsp_valid, rsp_result);
    end
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 1'b1, 4'b0110, 32'd9, 32'd9);
    set_req(1, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== (k[0] ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL cont_ready[%0d] got %b", k, req_ready);
      end
      if (k > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
          n_err++; $display("FAIL cont_bubble[%0d] got %b exp 1", k, rsp_valid);
        end
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        got = {rsp_result, rsp_zero, 1'b0, rsp_id};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL cont_rsp[%0d] got %h exp %h", k, got, e);
        end
      end
      if (k[0]) sb.push_back('{32'hFF, 1'b0, 2'd1});
      else      sb.push_back('{32'h0, 1'b1, 2'd0});
      @(posedge clk);
    end
    #1 req_valid = '0;
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (!rsp_valid || got !== e) begin
      n_err++; $display("FAIL cont_last got v=%b %h exp %h", rsp_valid, got, e);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL bp_first got %b exp 01", req_ready);
    end
    sb.push_back('{32'd3, 1'b0, 2'd0});
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'b0011, 32'hAA, 32'hAA);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_ready[%0d] got %b exp 00", k, req_ready);
      end
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_id} !==
          {1'b1, 32'd3, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h z=%b id=%h exp 1 3 0 0",
                 k, rsp_valid, rsp_result, rsp_zero, rsp_id);
      end
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_release got %b exp 10", req_ready);
    end
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (got !== e) begin
      n_err++; $display("FAIL bp_rsp0 got %h exp %h", got, e);
    end
    sb.push_back('{32'd0, 1'b1, 2'd1});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (!rsp_valid || got !== e) begin
      n_err++; $display("FAIL bp_rsp1 got v=%b %h exp %h", rsp_valid, got, e);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_req4(3, 1'b1, 4'b0010, 32'd3, 32'd3);
    rsp_ready_4 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready_4 !== 4'b1000) begin
      n_err++; $display("FAIL wrap_r3 got %b exp 1000", req_ready_4);
    end
    sb4.push_back('{32'd6, 1'b0, 2'd3});
    @(posedge clk); #1;
    set_req4(3, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req4(0, 1'b1, 4'b0000, 32'hF0, 32'h3C);
    @(negedge clk);
    n_cmp++;
    if (req_ready_4 !== 4'b0001) begin
      n_err++; $display("FAIL wrap_r0 got %b exp 0001", req_ready_4);
    end
    if (sb4.size() != 0) e = sb4.pop_front(); else e = 'x;
    got = {rsp_result_4, rsp_zero_4, rsp_id_4};
    n_cmp++;
    if (got !== e) begin
      n_err++; $display("FAIL wrap_rsp3 got %h exp %h", got, e);
    end
    sb4.push_back('{32'h30, 1'b0, 2'd0});
    @(posedge clk); #1;
    set_req4(0, 1'b1, 4'b0001, 32'd1, 32'd2);
    set_req4(1, 1'b1, 4'b0010, 32'h10, 32'h20);
    set_req4(3, 1'b1, 4'b0110, 32'd10, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready_4 !== ((k == 0) ? 4'b0010 :
                           (k == 1) ? 4'b1000 : 4'b0001)) begin
        n_err++; $display("FAIL wrap_seq[%0d] got %b", k, req_ready_4);
      end
      if (sb4.size() != 0) e = sb4.pop_front(); else e = 'x;
      got = {rsp_result_4, rsp_zero_4, rsp_id_4};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL wrap_rsp[%0d] got %h exp %h", k, got, e);
      end
      if (k == 0) sb4.push_back('{32'h30, 1'b0, 2'd1});
      if (k == 1) sb4.push_back('{32'd6, 1'b0, 2'd3});
      if (k == 2) sb4.push_back('{32'd3, 1'b0, 2'd0});
      @(posedge clk); #1;
      if (k == 0) req_valid_4[1] = 1'b0;
      if (k == 1) req_valid_4[3] = 1'b0;
      if (k == 2) req_valid_4 = '0;
    end
    @(negedge clk);
    if (sb4.size() != 0) e = sb4.pop_front(); else e = 'x;
    got = {rsp_result_4, rsp_zero_4, rsp_id_4};
    n_cmp++;
    if (!rsp_valid_4 || got !== e) begin
      n_err++; $display("FAIL wrap_last got v=%b %h exp %h", rsp_valid_4, got, e);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL mid_pending got v=%b rdy=%b exp 1 00", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL mid_rst_ready got %b exp 00", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL mid_after got v=%b rdy=%b exp 0 01", rsp_valid, req_ready);
    end
    sb.push_back('{32'd12, 1'b0, 2'd0});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL mid_second got %b exp 10", req_ready);
    end
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (got !== e) begin
      n_err++; $display("FAIL mid_rsp0 got %h exp %h", got, e);
    end
    sb.push_back('{32'hFF, 1'b0, 2'd1});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (!rsp_valid || got !== e) begin
      n_err++; $display("FAIL mid_rsp1 got v=%b %h exp %h", rsp_valid, got, e);
    end
  endtask

  task automatic test_sra();
    do_reset();
    set_req(1, 1'b1, 4'b1110, 32'h8000_0000, 32'd4);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, alu_op_o} !== {2'b10, 4'b1110}) begin
      n_err++;
      $display("FAIL sra_grant got rdy=%b op=%b exp 10 1110", req_ready, alu_op_o);
    end
    sb.push_back('{32'hF800_0000, 1'b0, 2'd1});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
    got = {rsp_result, rsp_zero, 1'b0, rsp_id};
    n_cmp++;
    if (!rsp_valid || got !== e) begin
      n_err++; $display("FAIL sra_rsp got v=%b %h exp %h", rsp_valid, got, e);
    end
  endtask

  task automatic test_random();
    int          m_rr;
    logic        m_vld;
    logic        free, fnd;
    int          g, idx;
    logic [1:0]  exp_rdy;
    logic [1:0]  gr;
    logic [32:0] r;
    do_reset();
    m_rr = 0;
    m_vld = 1'b0;
    gr = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || gr[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      free = !m_vld || rsp_ready;
      fnd = 1'b0;
      g = 0;
      for (int k = 0; k < 2; k++) begin
        idx = (m_rr + k) % 2;
        if (!fnd && req_valid[idx]) begin
          fnd = 1'b1;
          g = idx;
        end
      end
      exp_rdy = (free && fnd) ? 2'(1 << g) : 2'b00;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, exp_rdy);
      end
      n_cmp++;
      if (rsp_valid !== m_vld) begin
        n_err++; $display("FAIL rand_valid[%0d] got %b exp %b", c, rsp_valid, m_vld);
      end
      if (m_vld && rsp_ready) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        got = {rsp_result, rsp_zero, 1'b0, rsp_id};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL rand_rsp[%0d] got %h exp %h", c, got, e);
        end
      end
      if (free && fnd) begin
        r = alu_f(req_op1[g*32 +: 32], req_op2[g*32 +: 32],
                  req_alu_op[g*4 +: 4]);
        sb.push_back('{r[31:0], r[32], 2'(g)});
        m_vld = 1'b1;
        m_rr = (g == 1) ? 0 : g + 1;
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
      gr = exp_rdy;
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_sra();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
